// File: rtl/branch_predictor_ctrl.sv
// Branch history table of 2-bit saturating counters with a post-reset init walk,
// EX-stage counter updates, registered mispredict flush/redirect and a mispredict counter.
module branch_predictor_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IF_pc,
  output logic [1:0]      IF_branch_prediction,
  input  logic            EX_Branch,
  input  logic [XLEN-1:0] EX_pc,
  input  logic [XLEN-1:0] EX_target,
  input  logic [1:0]      prediction_status,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            bht_ready,
  output logic [31:0]     mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic                  flush_q, flush_d;
  logic [XLEN-1:0]       redirect_q, redirect_d;
  logic [31:0]           count_q, count_d;
  logic [1:0]            bht_q [DEPTH];

  logic [INDEX_BITS-1:0] ifIdx;
  logic [INDEX_BITS-1:0] exIdx;
  logic [1:0]            exEntry;
  logic [1:0]            exEntryNext;
  logic                  update;
  logic                  taken;
  logic                  mispredict;
  logic                  unusedIfPcBits;

  assign ifIdx      = IF_pc[INDEX_BITS+1:2];
  assign exIdx      = EX_pc[INDEX_BITS+1:2];
  assign exEntry    = bht_q[exIdx];
  assign update     = (state_q == RUN) && EX_Branch;
  assign taken      = (prediction_status == 2'd0) || (prediction_status == 2'd3);
  // Status 0 and 1 are the two mispredict encodings; both have bit 1 clear.
  assign mispredict = update && !prediction_status[1];

  assign unusedIfPcBits = ^{IF_pc[XLEN-1:INDEX_BITS+2], IF_pc[1:0]};

  // Table contents are undefined until the INIT walk forces them weakly-not-taken.
  assign IF_branch_prediction = (state_q == INIT) ? 2'b01 : bht_q[ifIdx];
  assign bht_ready            = (state_q == RUN);
  assign flush                = flush_q;
  assign redirect_pc          = redirect_q;
  assign mispredict_count     = count_q;

  always_comb begin
    exEntryNext = exEntry;
    if (taken && (exEntry != 2'b11)) begin
      exEntryNext = exEntry + 2'b01;
    end else if (!taken && (exEntry != 2'b00)) begin
      exEntryNext = exEntry - 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    flush_d    = 1'b0;
    redirect_d = redirect_q;
    count_d    = count_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (ptr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (mispredict) begin
          flush_d    = 1'b1;
          redirect_d = prediction_status[0] ? (EX_pc + XLEN'(4)) : EX_target;
          count_d    = count_q + 32'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      count_q    <= count_d;
    end
  end

  // The table has no reset; the INIT walk is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      bht_q[ptr_q] <= 2'b01;
    end else if (update) begin
      bht_q[exIdx] <= exEntryNext;
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl: directed test-plan steps plus a
// randomized phase, all compared against a behavioural BHT model kept here.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IF_pc;
  logic [1:0]  IF_branch_prediction;
  logic        EX_Branch;
  logic [31:0] EX_pc;
  logic [31:0] EX_target;
  logic [1:0]  prediction_status;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        bht_ready;
  logic [31:0] mispredict_count;

  int compared   = 0;
  int mismatched = 0;

  int          modelTable [64];
  logic [31:0] modelCount;
  logic [31:0] modelRedirect;
  bit          modelFlush;
  bit          modelReady;
  int          initCnt;

  branch_predictor_ctrl #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .IF_pc                (IF_pc),
    .IF_branch_prediction (IF_branch_prediction),
    .EX_Branch            (EX_Branch),
    .EX_pc                (EX_pc),
    .EX_target            (EX_target),
    .prediction_status    (prediction_status),
    .flush                (flush),
    .redirect_pc          (redirect_pc),
    .bht_ready            (bht_ready),
    .mispredict_count     (mispredict_count)
  );

  initial forever #5 clk = ~clk;

  function automatic int bhtIndex(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    modelReady    = 1'b0;
    initCnt       = 0;
    modelCount    = 32'd0;
    modelFlush    = 1'b0;
    modelRedirect = 32'd0;
  endtask

  task automatic applyStimulus(input logic br, input logic [31:0] expc, input logic [31:0] target,
                               input logic [1:0] st, input logic [31:0] ifpc);
    EX_Branch         = br;
    EX_pc             = expc;
    EX_target         = target;
    prediction_status = st;
    IF_pc             = ifpc;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".flush"},    32'(flush),      32'(modelFlush));
    checkOutput({tag, ".redirect"}, redirect_pc,     modelRedirect);
    checkOutput({tag, ".ready"},    32'(bht_ready),  32'(modelReady));
    checkOutput({tag, ".count"},    mispredict_count, modelCount);
  endtask

  task automatic checkPred(input string tag, input logic [31:0] ifpc);
    int exp;
    exp = modelReady ? modelTable[bhtIndex(ifpc)] : 1;
    checkOutput({tag, ".pred"}, 32'(IF_branch_prediction), 32'(exp));
  endtask

  // One clock: drive inputs, check the combinational lookup, then advance
  // the model across the edge and check the registered outputs.
  task automatic doCycle(input string tag, input logic br, input logic [31:0] expc,
                         input logic [31:0] target, input logic [1:0] st, input logic [31:0] ifpc);
    int i;
    applyStimulus(br, expc, target, st, ifpc);
    #1;
    checkPred(tag, ifpc);
    @(posedge clk);
    #1;
    if (modelReady) begin
      modelFlush = br && (st < 2);
      if (modelFlush) begin
        modelRedirect = (st == 2'd0) ? target : (expc + 32'd4);
        modelCount    = modelCount + 32'd1;
      end
      if (br) begin
        i = bhtIndex(expc);
        if (st == 2'd0 || st == 2'd3) modelTable[i] = (modelTable[i] < 3) ? modelTable[i] + 1 : 3;
        else                          modelTable[i] = (modelTable[i] > 0) ? modelTable[i] - 1 : 0;
      end
    end else begin
      modelFlush          = 1'b0;
      modelTable[initCnt] = 1;
      initCnt++;
      if (initCnt == 64) modelReady = 1'b1;
    end
    checkRegs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    resetModel();
    for (int i = 0; i < 64; i++) modelTable[i] = 1;
    #1;
    checkRegs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // INIT with mispredict-looking EX traffic that must be ignored
    for (int i = 0; i < 64; i++)
      doCycle("init", 1'b1, $urandom, $urandom, 2'd0, $urandom);
    checkOutput("readyAfter64", 32'(bht_ready), 32'd1);
    for (int i = 0; i < 64; i++)
      doCycle("scan", 1'b0, 32'd0, 32'd0, 2'd0, 32'(i * 4));

    // Saturation on 0x100: 01->10->11->11, then 10->01->00
    repeat (4) doCycle("satUp", 1'b1, 32'h100, 32'd0, 2'd3, 32'h100);
    repeat (3) doCycle("satDn", 1'b1, 32'h100, 32'd0, 2'd2, 32'h100);
    doCycle("satEnd", 1'b0, 32'd0, 32'd0, 2'd0, 32'h100);
    checkOutput("satFloor", 32'(IF_branch_prediction), 32'd0);

    // Mispredicted not-taken branch that was actually taken
    doCycle("mpT", 1'b1, 32'h200, 32'h2000, 2'd0, 32'd0);
    checkOutput("mpT.redirectConst", redirect_pc, 32'h2000);
    doCycle("mpTAfter", 1'b0, 32'd0, 32'd0, 2'd0, 32'd0);
    checkOutput("mpT.countConst", mispredict_count, 32'd1);

    // Mispredicted taken branch at the top of the address space wraps to 0
    doCycle("mpN", 1'b1, 32'hFFFF_FFFC, 32'h1234, 2'd1, 32'd0);
    checkOutput("mpN.wrapConst", redirect_pc, 32'd0);

    // Back-to-back mispredicts then a hold cycle
    doCycle("b2b0", 1'b1, 32'h80, 32'h5000, 2'd0, 32'd0);
    doCycle("b2b1", 1'b1, 32'h84, 32'h6000, 2'd1, 32'd0);
    doCycle("hold", 1'b1, 32'h88, 32'h7000, 2'd3, 32'd0);

    // Same-index read/write, then aliased PC sees the update
    doCycle("coll", 1'b1, 32'h40, 32'd0, 2'd3, 32'h40);
    doCycle("alias", 1'b0, 32'd0, 32'd0, 2'd0, 32'h140);
    checkOutput("alias.predConst", 32'(IF_branch_prediction), 32'd2);

    // Randomized traffic over a small, heavily aliased PC set
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pcA, pcB;
      pcA = 32'($urandom_range(0, 15)) * 32'd4 + (($urandom & 1) != 0 ? 32'h100 : 32'h0);
      pcB = 32'($urandom_range(0, 15)) * 32'd4 + (($urandom & 1) != 0 ? 32'h1100 : 32'h0);
      doCycle("rand", 1'($urandom_range(0, 1)), pcA, $urandom, 2'($urandom_range(0, 3)),
              (($urandom & 1) != 0) ? pcA : pcB);
    end

    // Async reset in the middle of a flush pulse
    doCycle("preRst", 1'b1, 32'h80, 32'h3000, 2'd0, 32'h80);
    rst_n = 1'b0;
    #1;
    resetModel();
    checkRegs("midRst");
    checkPred("midRst", 32'h80);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++)
      doCycle("reinit", 1'b1, $urandom, $urandom, 2'd1, $urandom);
    for (int i = 0; i < 64; i++)
      doCycle("rescan", 1'b0, 32'd0, 32'd0, 2'd0, 32'(i * 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
